bp_btb_predictor: RTL

Parametrised dynamic branch predictor for the pipelined RV32 core, replacing static not-taken fetch with flush-on-taken. It sits beside the fetch-stage PC register: fetch presents the current PC and receives a same-cycle predicted next-PC, and the branch-resolution point in decode/execute trains the tables. Storage is a direct-mapped BTB with per-entry 2-bit saturating counters plus an optional return-address stack.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bp_ras.sv | 65 ++++++
 rtl/bp_btb_predictor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the fetch-stage branch predictor: control-transfer
// types reported at resolution and the 2-bit saturating counter states.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_BR   = 2'b00,
    BP_JAL  = 2'b01,
    BP_CALL = 2'b10,
    BP_RET  = 2'b11
  } bp_type_e;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Saturating step; both strong states are sticky in their own direction.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case (ctr)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      default:   nxt = taken ? STRONG_T : WEAK_T;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Return-address stack trained at branch resolution. Circular storage:
// a push when full overwrites the oldest entry, a pop when empty does nothing.
module bp_ras
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [XLEN-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q is the next write slot, so the top sits one slot behind it.
  assign top_ptr = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
  assign top     = mem_q[top_ptr];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_addr;
      ptr_d        = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      if (!full) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_btb_predictor.sv
// Direct-mapped BTB with 2-bit counters giving a same-cycle next-PC prediction.
// Define BP_RAS_EN to add a return-address stack that predicts RET targets.
module bp_btb_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_W       = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lkp_valid,
  input  logic [XLEN-1:0] lkp_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  generate
    if (BTB_ENTRIES < 2 || (1 << IDX_W) != BTB_ENTRIES || RAS_DEPTH < 1 ||
        IDX_W + TAG_W + 2 > XLEN) begin : g_bad_cfg
      $error("bp_btb_predictor: unsupported parameter combination");
    end
  endgenerate

  logic            valid_q  [BTB_ENTRIES];
  logic            valid_d  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
  bp_type_e        type_q   [BTB_ENTRIES];
  bp_type_e        type_d   [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  logic [XLEN-1:0] target_d [BTB_ENTRIES];
  logic [1:0]      ctr_q    [BTB_ENTRIES];
  logic [1:0]      ctr_d    [BTB_ENTRIES];

  logic [IDX_W-1:0] lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  logic             lkp_hit, upd_hit, upd_is_br, upd_eff_taken, ret_from_ras;
  logic [XLEN-1:0]  ras_top;
  logic             ras_empty;
  logic             unused_pc_bits;

  assign lkp_idx = lkp_pc[IDX_W+1:2];
  assign lkp_tag = lkp_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{lkp_pc, upd_pc};

  assign lkp_hit       = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_is_br     = (upd_type == BP_BR);
  assign upd_eff_taken = !upd_is_br || upd_taken;

`ifdef BP_RAS_EN
  logic ras_full_unused;

  bp_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_valid && (upd_type == BP_CALL)),
    .pop       (upd_valid && (upd_type == BP_RET)),
    .push_addr (upd_pc + XLEN'(4)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

  // Lookup reads the flops directly, so an update in this cycle is not seen yet.
  assign ret_from_ras = (type_q[lkp_idx] == BP_RET) && !ras_empty;
  assign pred_taken   = lkp_valid && lkp_hit &&
                        ((type_q[lkp_idx] != BP_BR) || ctr_q[lkp_idx][1]);
  assign pred_target  = !lkp_hit     ? '0 :
                        ret_from_ras ? ras_top : target_q[lkp_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    type_d   = type_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_is_br) begin
          ctr_d[upd_idx] = ctr_step(ctr_q[upd_idx], upd_taken);
          if (upd_taken) begin
            target_d[upd_idx] = upd_target;
          end
        end else begin
          type_d[upd_idx]   = bp_type_e'(upd_type);
          target_d[upd_idx] = upd_target;
          ctr_d[upd_idx]    = STRONG_T;
        end
      end else if (upd_eff_taken) begin
        // Not-taken branches that miss never allocate, keeping the table for taken flow.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        type_d[upd_idx]   = bp_type_e'(upd_type);
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = upd_is_br ? WEAK_T : STRONG_T;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        type_q[i]   <= BP_BR;
        target_q[i] <= '0;
        ctr_q[i]    <= STRONG_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      type_q   <= type_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule
